// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-port ROM arbiter.
// Owner encoding and the per-port pending-request record.
package rom_arbiter_pkg;

    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
    } pend_t;

endpackage

// File: rtl/rom_pending.sv
// Single-entry capture buffer holding a request that lost arbitration.
// Capture has priority over clear; reset empties the entry.
module rom_pending
    import rom_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic        instr,
    input  logic [31:0] addr,
    output pend_t       entry
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry <= '0;
        end else if (capture) begin
            entry.valid <= 1'b1;
            entry.instr <= instr;
            entry.addr  <= addr;
        end else if (clear) begin
            entry.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates instruction and data ports onto one ROM with a fixed
// one-cycle response, routing each response back to its requester.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        rom_valid,
    output logic        rom_instr,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        rom_ready
);

    pend_t       ipend;
    pend_t       dpend;
    logic        inflight_q;
    logic        owner_q;
    logic        last_grant_q;
    logic        i_busy;
    logic        d_busy;
    logic        i_new;
    logic        d_new;
    logic        i_cand;
    logic        d_cand;
    logic        both;
    logic        grant;
    logic        i_instr;
    logic        d_instr;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic        resp;

    always_comb begin
        i_busy  = inflight_q && (owner_q == OWNER_IMEM) && !rom_ready;
        d_busy  = inflight_q && (owner_q == OWNER_DMEM) && !rom_ready;
        i_new   = imem_valid && !ipend.valid && !i_busy && !reset;
        d_new   = dmem_valid && !dpend.valid && !d_busy && !reset;
        i_cand  = ipend.valid || i_new;
        d_cand  = dpend.valid || d_new;
        i_instr = ipend.valid ? ipend.instr : imem_instr;
        i_addr  = ipend.valid ? ipend.addr  : imem_addr;
        d_instr = dpend.valid ? dpend.instr : dmem_instr;
        d_addr  = dpend.valid ? dpend.addr  : dmem_addr;
        both    = i_cand && d_cand;
        // Round-robin history only moves on contested cycles.
        if (both) begin
            if (FIXED_PRIO) begin
                grant = OWNER_IMEM;
            end else begin
                grant = (last_grant_q == OWNER_IMEM) ? OWNER_DMEM : OWNER_IMEM;
            end
        end else begin
            grant = d_cand ? OWNER_DMEM : OWNER_IMEM;
        end
        rom_valid = i_cand || d_cand;
        rom_instr = 1'b0;
        rom_addr  = '0;
        if (rom_valid) begin
            rom_instr = (grant == OWNER_DMEM) ? d_instr : i_instr;
            rom_addr  = (grant == OWNER_DMEM) ? d_addr  : i_addr;
        end
        resp       = inflight_q && rom_ready && !reset;
        imem_ready = resp && (owner_q == OWNER_IMEM);
        dmem_ready = resp && (owner_q == OWNER_DMEM);
        imem_rdata = imem_ready ? rom_rdata : '0;
        dmem_rdata = dmem_ready ? rom_rdata : '0;
    end

    rom_pending u_ipend (
        .clock   (clock),
        .reset   (reset),
        .capture (i_new && (grant == OWNER_DMEM)),
        .clear   (ipend.valid && (grant == OWNER_IMEM)),
        .instr   (imem_instr),
        .addr    (imem_addr),
        .entry   (ipend)
    );

    rom_pending u_dpend (
        .clock   (clock),
        .reset   (reset),
        .capture (d_new && (grant == OWNER_IMEM)),
        .clear   (dpend.valid && (grant == OWNER_DMEM)),
        .instr   (dmem_instr),
        .addr    (dmem_addr),
        .entry   (dpend)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            owner_q      <= OWNER_IMEM;
            last_grant_q <= OWNER_DMEM;
        end else begin
            inflight_q <= rom_valid;
            owner_q    <= grant;
            if (both) begin
                last_grant_q <= grant;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: round-robin and fixed-priority instances share
// stimulus, each with its own ROM and a request-level reference model.
module tb_rom_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        iv, ii, dv, di;
    logic [31:0] ia, da;
    logic        force_rdy;

    logic [31:0] ir    [2];
    logic        irdy  [2];
    logic [31:0] dr    [2];
    logic        drdy  [2];
    logic        rv    [2];
    logic        rinstr[2];
    logic [31:0] raddr [2];
    logic [31:0] rrdata[2];
    logic        rrdy  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h41014081;
            32'h04: return 32'h42014181;
            32'h08: return 32'h43014281;
            32'h3C: return 32'h3C3C0013;
            32'h40: return 32'h80678000;
            32'h44: return 32'h00000002;
            default: return {a[15:0], ~a[15:0]} ^ 32'h5A5A0000;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rom_arbiter #(.FIXED_PRIO(g[0])) dut (
            .clock      (clock),
            .reset      (reset),
            .imem_valid (iv),
            .imem_instr (ii),
            .imem_addr  (ia),
            .imem_rdata (ir[g]),
            .imem_ready (irdy[g]),
            .dmem_valid (dv),
            .dmem_instr (di),
            .dmem_addr  (da),
            .dmem_rdata (dr[g]),
            .dmem_ready (drdy[g]),
            .rom_valid  (rv[g]),
            .rom_instr  (rinstr[g]),
            .rom_addr   (raddr[g]),
            .rom_rdata  (rrdata[g]),
            .rom_ready  (rrdy[g])
        );

        always @(posedge clock) begin
            rrdy[g]   <= rv[g] | force_rdy;
            rrdata[g] <= rv[g] ? rom_word(raddr[g]) : 32'hDEADBEEF;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-port waiting request, last contest winner,
    // and the request sent to the ROM in the previous cycle.
    bit          pv [2][2];
    bit          pi [2][2];
    logic [31:0] pa [2][2];
    bit          lastc[2] = '{1'b1, 1'b1};
    bit          fv [2];
    bit          fo [2];
    logic [31:0] fa [2];

    task automatic model_step(input int d);
        bit          vin[2];
        bit          iin[2];
        logic [31:0] ain[2];
        bit          legal[2];
        bit          cand[2];
        bit          ri[2];
        logic [31:0] ra[2];
        bit          ex_ok[2];
        logic [31:0] ex_rd[2];
        bit          w;
        bit          any;
        vin[0] = iv; iin[0] = ii; ain[0] = ia;
        vin[1] = dv; iin[1] = di; ain[1] = da;
        if (reset) begin
            chk($sformatf("d%0d rst rom_valid", d), rv[d], 0);
            chk($sformatf("d%0d rst imem_ready", d), irdy[d], 0);
            chk($sformatf("d%0d rst dmem_ready", d), drdy[d], 0);
            chk($sformatf("d%0d rst imem_rdata", d), ir[d], 0);
            chk($sformatf("d%0d rst dmem_rdata", d), dr[d], 0);
            for (int p = 0; p < 2; p++) pv[d][p] = 0;
            lastc[d] = 1;
            fv[d]    = 0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            ex_ok[p] = fv[d] && (fo[d] == p[0]);
            ex_rd[p] = ex_ok[p] ? rom_word(fa[d]) : 32'h0;
            legal[p] = vin[p] && !pv[d][p];
            cand[p]  = pv[d][p] || legal[p];
            ri[p]    = pv[d][p] ? pi[d][p] : iin[p];
            ra[p]    = pv[d][p] ? pa[d][p] : ain[p];
        end
        chk($sformatf("d%0d imem_ready", d), irdy[d], ex_ok[0]);
        chk($sformatf("d%0d imem_rdata", d), ir[d], ex_rd[0]);
        chk($sformatf("d%0d dmem_ready", d), drdy[d], ex_ok[1]);
        chk($sformatf("d%0d dmem_rdata", d), dr[d], ex_rd[1]);
        any = cand[0] || cand[1];
        if (cand[0] && cand[1]) begin
            w = (d == 1) ? 1'b0 : !lastc[d];
            lastc[d] = w;
        end else begin
            w = cand[1];
        end
        chk($sformatf("d%0d rom_valid", d), rv[d], any);
        if (any) begin
            chk($sformatf("d%0d rom_addr", d), raddr[d], ra[w]);
            chk($sformatf("d%0d rom_instr", d), rinstr[d], ri[w]);
            pv[d][w] = 0;
            if (legal[!w]) begin
                pv[d][!w] = 1;
                pi[d][!w] = iin[!w];
                pa[d][!w] = ain[!w];
            end
        end
        fv[d] = any;
        fo[d] = w;
        fa[d] = ra[w];
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic drive(input bit vi, input logic [31:0] ai,
                         input bit vd, input logic [31:0] ad);
        @(posedge clock);
        #1;
        iv = vi; ia = ai; ii = vi;
        dv = vd; da = ad; di = vd & ad[3];
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        iv = 0; dv = 0;
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        force_rdy = 1'b0;
        iv = 0; ii = 0; ia = 0;
        dv = 0; di = 0; da = 0;

        // Outputs held low during reset even with a request present
        @(posedge clock);
        @(posedge clock);
        #1;
        iv = 1; ia = 32'h0; ii = 1;
        @(negedge clock);
        chk("rst rom_valid d0", rv[0], 0);
        chk("rst rom_valid d1", rv[1], 0);
        chk("rst imem_ready d0", irdy[0], 0);

        // Grant in first cycle after deassertion, single imem access
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("first rom_valid", rv[0], 1);
        chk("first rom_addr", raddr[0], 32'h0);
        drive(0, 0, 0, 0);
        chk("single imem_ready", irdy[0], 1);
        chk("single imem_rdata", ir[0], 32'h41014081);
        chk("single dmem_ready", drdy[0], 0);

        // Tie after reset: imem first, dmem one cycle later
        do_reset();
        drive(1, 32'h40, 1, 32'h44);
        chk("tie rom_addr", raddr[0], 32'h40);
        drive(0, 0, 0, 0);
        chk("tie imem_ready", irdy[0], 1);
        chk("tie imem_rdata", ir[0], 32'h80678000);
        chk("tie pend addr", raddr[0], 32'h44);
        drive(0, 0, 0, 0);
        chk("tie dmem_ready", drdy[0], 1);
        chk("tie dmem_rdata", dr[0], 32'h00000002);
        chk("tie imem idle", irdy[0], 0);

        // Repeated ties: round-robin alternates, fixed-prio stays on imem
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h10 + 8 * k, 1, 32'h14 + 8 * k);
            chk($sformatf("rr%0d winner", k), raddr[0],
                (k % 2 == 0) ? 32'h14 + 8 * k : 32'h10 + 8 * k);
            chk($sformatf("fp%0d winner", k), raddr[1], 32'h10 + 8 * k);
            drive(0, 0, 0, 0);
        end

        // Fixed priority with dmem pulsing; mid pulse collides with pending
        drive(1, 32'h04, 1, 32'h3C);
        chk("fp imem first", raddr[1], 32'h04);
        chk("fp imem instr", rinstr[1], 1);
        drive(0, 0, 1, 32'h50);
        chk("fp imem_ready", irdy[1], 1);
        chk("fp imem_rdata", ir[1], 32'h42014181);
        chk("fp pending wins", raddr[1], 32'h3C);
        drive(0, 0, 1, 32'h3C);
        chk("fp dmem_ready", drdy[1], 1);
        chk("fp dmem_rdata", dr[1], 32'h3C3C0013);
        chk("fp dmem reissue", raddr[1], 32'h3C);
        drive(0, 0, 0, 0);
        chk("fp dmem_ready 2", drdy[1], 1);

        // Asynchronous reset with dmem in flight and imem pending
        do_reset();
        drive(1, 32'h20, 1, 32'h24);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 32'h28, 1, 32'h2C);
        chk("pre dmem won", raddr[0], 32'h2C);
        @(posedge clock);
        #1;
        iv = 0; dv = 0;
        #1;
        chk("pre rst dmem_ready", drdy[0], 1);
        chk("pre rst rom_valid", rv[0], 1);
        reset = 1'b1;
        #1;
        chk("async rom_valid", rv[0], 0);
        chk("async dmem_ready", drdy[0], 0);
        chk("async dmem_rdata", dr[0], 0);
        chk("async imem_ready", irdy[0], 0);
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0);
            chk("post rst imem_ready", irdy[0], 0);
            chk("post rst dmem_ready", drdy[0], 0);
            chk("post rst rom_valid", rv[0], 0);
        end
        drive(1, 32'h08, 0, 0);
        drive(0, 0, 0, 0);
        chk("post imem_ready", irdy[0], 1);
        chk("post imem_rdata", ir[0], 32'h43014281);

        // Stale ROM ready with nothing in flight
        force_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0);
            chk("stale imem_ready d0", irdy[0], 0);
            chk("stale dmem_ready d0", drdy[0], 0);
            chk("stale dmem_ready d1", drdy[1], 0);
        end
        force_rdy = 1'b0;
        drive(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0; 0 = round-robin, 1 = instruction port always wins.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 imem_valid  in  1; imem_instr  in  1; imem_addr  in  32  instruction-port request, one-cycle pulse.
REQ-005 imem_rdata  out  32; imem_ready  out  1  instruction-port response.
REQ-006 dmem_valid  in  1; dmem_instr  in  1; dmem_addr  in  32  data-port request, one-cycle pulse.
REQ-007 dmem_rdata  out  32; dmem_ready  out  1  data-port response.
REQ-008 rom_valid  out  1; rom_instr  out  1; rom_addr  out  32  request to the shared ROM.
REQ-009 rom_rdata  in  32; rom_ready  in  1  ROM response, fixed one cycle after rom_valid.

Function
REQ-010 Candidate per port = its valid pulse this cycle OR its pending entry; pending entry wins over a new pulse on the same port.
REQ-011 At most one ROM request per cycle; rom_valid/instr/addr are driven combinationally from the granted candidate, in the same cycle as the request.
REQ-012 Single candidate: granted immediately; response arrives next cycle, giving 1-cycle latency, the same as direct ROM access.
REQ-013 Both candidates, FIXED_PRIO=0: grant the port not granted last; last_grant resets to data, so the instruction port wins the first tie.
REQ-014 Both candidates, FIXED_PRIO=1: instruction port always granted.
REQ-015 Losing new pulse: captured into that port's pending entry (instr, addr) at the clock edge; pending is one entry per port.
REQ-016 A pending entry is issued in the earliest cycle it wins arbitration and is cleared on that edge.
REQ-017 New valid on a port whose pending entry is set, or whose request is in flight and not yet answered: protocol violation, pulse ignored, state unchanged.
REQ-018 Registers inflight_q (1 bit) and owner_q (1 bit, 0=imem, 1=dmem) record the request issued in the previous cycle.
REQ-019 When rom_ready=1 and inflight_q=1: rom_rdata is routed to the owner_q port, and that port's ready=1 for exactly one cycle.
REQ-020 rom_ready while inflight_q=0 (stale ROM ready) is discarded; neither port's ready is asserted.
REQ-021 Non-owner port: ready=0 and rdata=0 every cycle.
REQ-022 Back-to-back: a new grant may issue in the same cycle a response is returned, sustaining one ROM access per cycle.
REQ-023 Worst-case latency for a port under contention is 2 cycles (pulse -> ready).

Reset
REQ-024 Asynchronous assertion clears pending valid bits, inflight_q and owner_q, and sets last_grant=data, with no clock required.
REQ-025 During reset: rom_valid=0, imem_ready=0, dmem_ready=0, all rdata=0.
REQ-026 Reset mid-operation abandons the in-flight and pending requests; no ready is issued for them after deassertion.
REQ-027 First grant is possible in the first cycle after deassertion.

Structure
REQ-028 Shared configure package holds the owner encoding constants (OWNER_IMEM=0, OWNER_DMEM=1) and the pending-entry struct (valid, instr, addr[31:0]).
REQ-029 One sub-module, rom_pending: a single-entry capture buffer, instantiated once per port.
REQ-030 Arbitration and response routing stay in rom_arbiter; no other hierarchy.

Verification (bench uses the testbench ROM image)
REQ-031 imem pulse, addr 0x0, alone -> rom_valid same cycle; imem_ready next cycle, imem_rdata=0x41014081, dmem_ready=0.
REQ-032 imem addr 0x40 and dmem addr 0x44 in the same cycle, FIXED_PRIO=0, after reset -> imem_ready at T+1 with 0x80678000; dmem_ready at T+2 with 0x00000002.
REQ-033 Repeated simultaneous pulses every 2 cycles, FIXED_PRIO=0 -> the first-served port alternates; no port waits more than 2 cycles.
REQ-034 dmem pulse addr 0x3C every cycle it is legal, plus imem pulse addr 0x04, FIXED_PRIO=1 -> imem always served first: imem_rdata=0x42014181 at T+1.
REQ-035 Reset asserted asynchronously mid-cycle while a dmem request is in flight and an imem request is pending -> outputs go to 0 immediately; no ready after deassertion; the next imem addr 0x08 returns 0x43014281.
REQ-036 rom_ready forced high with no request issued -> imem_ready=0 and dmem_ready=0.
